// File: rtl/regstate_pkg.sv
// Shared encodings for the regstate architectural-state holder: FSM states,
// load-word indices (same order as the REG_* selectors) and reset values.
package regstate_pkg;

    typedef enum logic [1:0] {
        RS_IDLE = 2'd0,
        RS_LOAD = 2'd1,
        RS_RUN  = 2'd2,
        RS_HALT = 2'd3
    } rs_state_t;

    localparam int NUM_REGS = 10;

    localparam logic [3:0] LD_EAX    = 4'd0;
    localparam logic [3:0] LD_EBX    = 4'd1;
    localparam logic [3:0] LD_ECX    = 4'd2;
    localparam logic [3:0] LD_EDX    = 4'd3;
    localparam logic [3:0] LD_ESI    = 4'd4;
    localparam logic [3:0] LD_EDI    = 4'd5;
    localparam logic [3:0] LD_ESP    = 4'd6;
    localparam logic [3:0] LD_EBP    = 4'd7;
    localparam logic [3:0] LD_EIP    = 4'd8;
    localparam logic [3:0] LD_EFLAGS = 4'd9;

    // Bit 1 of EFLAGS is architecturally reserved and always reads as one.
    localparam logic [31:0] EFLAGS_RESET = 32'h0000_0002;

    function automatic logic [31:0] reg_reset(input int i);
        return (i == int'(LD_EFLAGS)) ? EFLAGS_RESET : 32'h0;
    endfunction

endpackage

// File: rtl/regstate.sv
// Architectural-state holder in front of regfile: word-serial initial load,
// per-step commit of regfile results, step counting and load/run/halt control.
module regstate
    import regstate_pkg::*;
#(
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    input  logic              step_valid,
    output logic              step_ready,
    input  logic [31:0]       c_eax,
    input  logic [31:0]       c_ebx,
    input  logic [31:0]       c_ecx,
    input  logic [31:0]       c_edx,
    input  logic [31:0]       c_esi,
    input  logic [31:0]       c_edi,
    input  logic [31:0]       c_esp,
    input  logic [31:0]       c_ebp,
    input  logic [31:0]       c_eip,
    input  logic [31:0]       c_eflags,
    input  logic              halt_req,
    input  logic              clear,
    output logic [31:0]       s_eax,
    output logic [31:0]       s_ebx,
    output logic [31:0]       s_ecx,
    output logic [31:0]       s_edx,
    output logic [31:0]       s_esi,
    output logic [31:0]       s_edi,
    output logic [31:0]       s_esp,
    output logic [31:0]       s_ebp,
    output logic [31:0]       s_eip,
    output logic [31:0]       s_eflags,
    output logic              rf_en,
    output logic              state_valid,
    output logic              done,
    output logic [STEP_W-1:0] step_count,
    output logic              ovf,
    output rs_state_t         dbg_state
);

    rs_state_t   state, state_nx;
    logic [3:0]  idx;
    logic [31:0] regs [NUM_REGS];
    logic [31:0] c_in [NUM_REGS];
    logic        ld_fire, step_fire, ld_last;

    // Handshakes: a word/step transfers on a rising edge where valid && ready;
    // ready is a pure function of state, and valid may rise without waiting for ready.
    assign ld_ready    = (state == RS_LOAD);
    assign step_ready  = (state == RS_RUN);
    assign state_valid = (state == RS_RUN);
    assign done        = (state == RS_HALT);
    assign dbg_state   = state;

    assign ld_fire   = ld_valid && ld_ready;
    assign step_fire = step_valid && step_ready;
    assign ld_last   = ld_fire && (idx == LD_EFLAGS);
    assign rf_en     = step_fire;

    assign c_in[0] = c_eax;
    assign c_in[1] = c_ebx;
    assign c_in[2] = c_ecx;
    assign c_in[3] = c_edx;
    assign c_in[4] = c_esi;
    assign c_in[5] = c_edi;
    assign c_in[6] = c_esp;
    assign c_in[7] = c_ebp;
    assign c_in[8] = c_eip;
    assign c_in[9] = c_eflags;

    assign s_eax    = regs[0];
    assign s_ebx    = regs[1];
    assign s_ecx    = regs[2];
    assign s_edx    = regs[3];
    assign s_esi    = regs[4];
    assign s_edi    = regs[5];
    assign s_esp    = regs[6];
    assign s_ebp    = regs[7];
    assign s_eip    = regs[8];
    assign s_eflags = regs[9];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RS_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            RS_IDLE: if (start) state_nx = RS_LOAD;
            // halt wins over finishing the load; the last word is still written
            RS_LOAD: begin
                if (halt_req)     state_nx = RS_HALT;
                else if (ld_last) state_nx = RS_RUN;
            end
            RS_RUN:  if (halt_req) state_nx = RS_HALT;
            RS_HALT: if (clear) state_nx = RS_IDLE;
            default: state_nx = RS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= 4'd0;
        end else if (state == RS_IDLE && start) begin
            idx <= 4'd0;
        end else if (ld_fire) begin
            idx <= idx + 4'd1;
        end
    end

    // Per-word mux: commit input, load word, or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= reg_reset(i);
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (step_fire)                        regs[i] <= c_in[i];
                else if (ld_fire && idx == 4'(i))     regs[i] <= ld_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_count <= '0;
            ovf        <= 1'b0;
        end else if (ld_last && !halt_req) begin
            step_count <= '0;
        end else if (step_fire) begin
            step_count <= step_count + 1'b1;
            if (&step_count) ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regstate.sv
// Bench for regstate: a vector table for load/run/halt sequencing plus
// hand-written sequences for full load, counter wrap, partial load and async reset.
module tb_regstate;
    import regstate_pkg::*;

    localparam int STEP_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0, ld_valid = 1'b0, step_valid = 1'b0;
    logic              halt_req = 1'b0, clear = 1'b0;
    logic [31:0]       ld_data = '0;
    logic [31:0]       c_arr [10];
    logic [31:0]       s_arr [10];
    logic              ld_ready, step_ready, rf_en, state_valid, done, ovf;
    logic [STEP_W-1:0] step_count;
    rs_state_t         dbg_state;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regstate #(.STEP_W(STEP_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .step_valid(step_valid), .step_ready(step_ready),
        .c_eax(c_arr[0]), .c_ebx(c_arr[1]), .c_ecx(c_arr[2]), .c_edx(c_arr[3]),
        .c_esi(c_arr[4]), .c_edi(c_arr[5]), .c_esp(c_arr[6]), .c_ebp(c_arr[7]),
        .c_eip(c_arr[8]), .c_eflags(c_arr[9]),
        .halt_req(halt_req), .clear(clear),
        .s_eax(s_arr[0]), .s_ebx(s_arr[1]), .s_ecx(s_arr[2]), .s_edx(s_arr[3]),
        .s_esi(s_arr[4]), .s_edi(s_arr[5]), .s_esp(s_arr[6]), .s_ebp(s_arr[7]),
        .s_eip(s_arr[8]), .s_eflags(s_arr[9]),
        .rf_en(rf_en), .state_valid(state_valid), .done(done),
        .step_count(step_count), .ovf(ovf), .dbg_state(dbg_state)
    );

    typedef struct {
        logic        start, ld_valid, step_valid, halt_req, clear;
        logic [31:0] ld_data, c_eax;
        logic        e_ld_ready, e_step_ready, e_rf_en;
        rs_state_t   e_state;
        logic        e_state_valid, e_done;
        logic [31:0] e_s_eax, e_s_eflags;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Commit inputs are derived from c_eax so every register gets a distinct value.
    task automatic drive(input logic st, input logic lv, input logic [31:0] ld,
                         input logic sv, input logic [31:0] ce, input logic hr, input logic cl);
        start = st; ld_valid = lv; ld_data = ld; step_valid = sv;
        halt_req = hr; clear = cl;
        for (int k = 0; k < 10; k++) c_arr[k] = ce + 32'(k);
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic st, input logic lv, input logic [31:0] ld,
                                input logic sv, input logic [31:0] ce, input logic hr,
                                input logic cl, input logic elr, input logic esr,
                                input logic erf, input rs_state_t es, input logic esv,
                                input logic edn, input logic [31:0] eax,
                                input logic [31:0] efl, input logic [3:0] ecn);
        vec_t v;
        v.start = st; v.ld_valid = lv; v.ld_data = ld; v.step_valid = sv;
        v.c_eax = ce; v.halt_req = hr; v.clear = cl;
        v.e_ld_ready = elr; v.e_step_ready = esr; v.e_rf_en = erf;
        v.e_state = es; v.e_state_valid = esv; v.e_done = edn;
        v.e_s_eax = eax; v.e_s_eflags = efl; v.e_cnt = ecn;
        return v;
    endfunction

    initial begin
        idle_in();
        // ---- table: ignored load in IDLE, start, gapped load, steps, halt, clear
        vecs.push_back(mk(0,1,32'h99,0,0,0,0, 0,0,0, RS_IDLE,0,0, 32'h0,32'h2,4'd0));
        vecs.push_back(mk(1,0,32'h0,0,0,0,0,  0,0,0, RS_LOAD,0,0, 32'h0,32'h2,4'd0));
        for (int i = 0; i < 10; i++) begin
            vecs.push_back(mk(0,1,32'h11 + 32'(i),0,0,0,0, 1,0,0,
                              (i == 9) ? RS_RUN : RS_LOAD, (i == 9), 0,
                              32'h11, (i == 9) ? 32'h1A : 32'h2, 4'd0));
            if (i < 9)
                vecs.push_back(mk(0,0,32'hDEAD,0,0,0,0, 1,0,0, RS_LOAD,0,0,
                                  32'h11, 32'h2, 4'd0));
        end
        vecs.push_back(mk(0,0,0,1,32'd1,0,0, 0,1,1, RS_RUN,1,0, 32'd1,32'd10,4'd1));
        vecs.push_back(mk(0,0,0,1,32'd2,0,0, 0,1,1, RS_RUN,1,0, 32'd2,32'd11,4'd2));
        vecs.push_back(mk(0,0,0,1,32'd3,0,0, 0,1,1, RS_RUN,1,0, 32'd3,32'd12,4'd3));
        vecs.push_back(mk(0,0,0,0,32'd9,0,0, 0,1,0, RS_RUN,1,0, 32'd3,32'd12,4'd3));
        vecs.push_back(mk(1,1,32'h55,0,0,0,0, 0,1,0, RS_RUN,1,0, 32'd3,32'd12,4'd3));
        vecs.push_back(mk(0,0,0,1,32'hFF8,1,0, 0,1,1, RS_HALT,0,1, 32'hFF8,32'h1001,4'd4));
        vecs.push_back(mk(0,0,0,1,32'd7,0,0, 0,0,0, RS_HALT,0,1, 32'hFF8,32'h1001,4'd4));
        vecs.push_back(mk(0,0,0,0,0,0,1, 0,0,0, RS_IDLE,0,0, 32'hFF8,32'h1001,4'd4));

        // ---- reset state
        #23;
        chk("rst_s_eax", s_arr[0], 32'h0);
        chk("rst_s_eip", s_arr[8], 32'h0);
        chk("rst_s_eflags", s_arr[9], 32'h2);
        chk("rst_cnt", 32'(step_count), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_readies", {30'h0, ld_ready, step_ready}, 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(RS_IDLE));
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, vecs[i].ld_valid, vecs[i].ld_data, vecs[i].step_valid,
                  vecs[i].c_eax, vecs[i].halt_req, vecs[i].clear);
            #1;
            chk($sformatf("v%0d_ld_ready", i), 32'(ld_ready), 32'(vecs[i].e_ld_ready));
            chk($sformatf("v%0d_step_ready", i), 32'(step_ready), 32'(vecs[i].e_step_ready));
            chk($sformatf("v%0d_rf_en", i), 32'(rf_en), 32'(vecs[i].e_rf_en));
            tick();
            chk($sformatf("v%0d_state", i), 32'(dbg_state), 32'(vecs[i].e_state));
            chk($sformatf("v%0d_state_valid", i), 32'(state_valid), 32'(vecs[i].e_state_valid));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].e_done));
            chk($sformatf("v%0d_s_eax", i), s_arr[0], vecs[i].e_s_eax);
            chk($sformatf("v%0d_s_eflags", i), s_arr[9], vecs[i].e_s_eflags);
            chk($sformatf("v%0d_cnt", i), 32'(step_count), 32'(vecs[i].e_cnt));
        end
        chk("halt_s_eip", s_arr[8], 32'h1000);

        // ---- back-to-back load of all ten registers, then counter wrap
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 32'h21 + 32'(i), 0, 0, 0, 0);
            #1;
            chk("full_ld_ready", 32'(ld_ready), 32'h1);
            tick();
        end
        chk("full_state_valid", 32'(state_valid), 32'h1);
        chk("full_cnt", 32'(step_count), 32'h0);
        for (int k = 0; k < 10; k++)
            chk($sformatf("full_reg%0d", k), s_arr[k], 32'h21 + 32'(k));
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 1, 32'h100 + 32'(i), 0, 0);
            tick();
            if (i == 14) begin
                chk("wrap_cnt15", 32'(step_count), 32'd15);
                chk("wrap_ovf_pre", 32'(ovf), 32'h0);
            end
        end
        chk("wrap_cnt", 32'(step_count), 32'h0);
        chk("wrap_ovf", 32'(ovf), 32'h1);
        chk("wrap_s_eax", s_arr[0], 32'h10F);
        drive(0, 0, 0, 0, 0, 1, 0);
        tick();
        chk("wrap_done", 32'(done), 32'h1);
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        chk("restart_state", 32'(dbg_state), 32'(RS_LOAD));
        chk("restart_ovf", 32'(ovf), 32'h1);

        // ---- halt during load keeps partially loaded registers
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 32'h31 + 32'(i), 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        tick();
        chk("part_state", 32'(dbg_state), 32'(RS_HALT));
        chk("part_s_eax", s_arr[0], 32'h31);
        chk("part_s_ecx", s_arr[2], 32'h33);
        chk("part_s_edx", s_arr[3], 32'h112);
        chk("part_ovf", 32'(ovf), 32'h1);

        // ---- asynchronous reset in the middle of RUN
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 32'h41 + 32'(i), 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 1, 32'h500, 0, 0);
        tick();
        chk("mid_run_cnt", 32'(step_count), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(dbg_state), 32'(RS_IDLE));
        chk("arst_s_eax", s_arr[0], 32'h0);
        chk("arst_s_eflags", s_arr[9], 32'h2);
        chk("arst_cnt", 32'(step_count), 32'h0);
        chk("arst_ovf", 32'(ovf), 32'h0);
        chk("arst_readies", {30'h0, ld_ready, step_ready}, 32'h0);
        chk("arst_rf_en", 32'(rf_en), 32'h0);
        #3;
        rst_n = 1'b1;
        idle_in();
        tick();
        chk("post_rst_state", 32'(dbg_state), 32'(RS_IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
